ama_riscv_mem_arbiter: RTL and testbench

//   Shares the single 128-bit main-memory port between the I$ and D$ at cache-line granularity.

---
 rtl/ama_riscv_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ama_riscv_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// rtl/ama_riscv_mem_arbiter.sv - cache-line arbiter sharing one memory beat port between I$ and D$
//
// Purpose: accepts one line request at a time from the I$ (read) or D$ (read or
// writeback), issues it to memory as BEATS beats, reassembles read beats into a
// line and pulses the owner's rsp_valid once the line is complete or the last
// write beat has been accepted.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ic_req_* / ic_rsp_*        I$ line read request / response
//   dc_req_* / dc_rsp_*        D$ line read or writeback request / response
//   mem_req_* / mem_rsp_*      memory beat request / in-order read beat return
//   busy                       transaction in flight
// Configuration: MEM_ARB_DC_PRIO_EN selects fixed D$ priority instead of round-robin.

module ama_riscv_mem_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 128,
    parameter int BEATS = 4,
    parameter int CLW   = DW * BEATS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ic_req_valid,
    output logic            ic_req_ready,
    input  logic [AW-1:0]   ic_req_addr,
    output logic            ic_rsp_valid,
    output logic [CLW-1:0]  ic_rsp_data,
    input  logic            dc_req_valid,
    output logic            dc_req_ready,
    input  logic [AW-1:0]   dc_req_addr,
    input  logic            dc_req_we,
    input  logic [CLW-1:0]  dc_req_wdata,
    output logic            dc_rsp_valid,
    output logic [CLW-1:0]  dc_rsp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_we,
    output logic [DW-1:0]   mem_req_wdata,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_data,
    output logic            busy
);

    localparam int BW    = $clog2(BEATS);
    localparam int CNT_W = BW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RD, DONE} state_t;

    state_t            state;
    logic              owner_dc;
    logic              we_q;
    logic [AW-BW-1:0]  line_addr;
    logic [BW-1:0]     beat_cnt;
    logic [CNT_W-1:0]  rsp_cnt;
    logic [CLW-1:0]    line;

    logic gnt_ic;
    logic gnt_dc;
    logic accept;
    logic rsp_in;
    logic rd_all;

    // Beat-offset bits of the request address are replaced by beat_cnt.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{ic_req_addr[BW-1:0], dc_req_addr[BW-1:0]};

`ifdef MEM_ARB_DC_PRIO_EN
    assign gnt_dc = dc_req_valid;
    assign gnt_ic = ic_req_valid && !dc_req_valid;
`else
    // rr_dc remembers the last owner; on a tie the other requester wins.
    logic rr_dc;
    assign gnt_dc = dc_req_valid && (!ic_req_valid || !rr_dc);
    assign gnt_ic = ic_req_valid && (!dc_req_valid ||  rr_dc);
`endif

    assign ic_req_ready = rst_n && (state == IDLE) && gnt_ic;
    assign dc_req_ready = rst_n && (state == IDLE) && gnt_dc;
    assign accept       = (ic_req_valid && ic_req_ready) || (dc_req_valid && dc_req_ready);

    // Read beats may already be returning while later beats are still being sent.
    assign rsp_in = mem_rsp_valid && !we_q && ((state == SEND) || (state == WAIT_RD));
    assign rd_all = (rsp_cnt + {{BW{1'b0}}, rsp_in}) == CNT_W'(BEATS);

    assign mem_req_valid = (state == SEND);
    assign mem_req_we    = (state == SEND) && we_q;
    assign mem_req_addr  = {line_addr, beat_cnt};
    assign mem_req_wdata = line[DW*beat_cnt +: DW];

    assign ic_rsp_valid  = (state == DONE) && !owner_dc;
    assign dc_rsp_valid  = (state == DONE) &&  owner_dc;
    assign ic_rsp_data   = line;
    assign dc_rsp_data   = line;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_dc  <= 1'b0;
            we_q      <= 1'b0;
            line_addr <= '0;
            beat_cnt  <= '0;
            rsp_cnt   <= '0;
            line      <= '0;
`ifndef MEM_ARB_DC_PRIO_EN
            rr_dc     <= 1'b0;
`endif
        end else begin
            if (rsp_in) begin
                line[DW*rsp_cnt[BW-1:0] +: DW] <= mem_rsp_data;
                rsp_cnt <= rsp_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_dc  <= gnt_dc;
                        we_q      <= gnt_dc && dc_req_we;
                        line_addr <= gnt_dc ? dc_req_addr[AW-1:BW] : ic_req_addr[AW-1:BW];
                        beat_cnt  <= '0;
                        rsp_cnt   <= '0;
                        if (gnt_dc && dc_req_we) line <= dc_req_wdata;
`ifndef MEM_ARB_DC_PRIO_EN
                        rr_dc     <= gnt_dc;
`endif
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (mem_req_ready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BW'(BEATS - 1)) begin
                            state <= (we_q || rd_all) ? DONE : WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (rd_all) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && mem_rsp_valid && ((state == IDLE) || (state == DONE))) begin
            $error("mem arbiter: unexpected memory response outside a read");
        end
    end
`endif

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// tb/tb_ama_riscv_mem_arbiter.sv - directed self-checking bench for ama_riscv_mem_arbiter

module tb_ama_riscv_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ic_req_valid = 1'b0;
    logic         ic_req_ready;
    logic [11:0]  ic_req_addr = '0;
    logic         ic_rsp_valid;
    logic [511:0] ic_rsp_data;
    logic         dc_req_valid = 1'b0;
    logic         dc_req_ready;
    logic [11:0]  dc_req_addr = '0;
    logic         dc_req_we = 1'b0;
    logic [511:0] dc_req_wdata = '0;
    logic         dc_rsp_valid;
    logic [511:0] dc_rsp_data;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b1;
    logic [11:0]  mem_req_addr;
    logic         mem_req_we;
    logic [127:0] mem_req_wdata;
    logic         mem_rsp_valid = 1'b0;
    logic [127:0] mem_rsp_data = '0;
    logic         busy;

    ama_riscv_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_we(dc_req_we), .dc_req_wdata(dc_req_wdata),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Memory model state and observation logs
    logic         auto_rsp   = 1'b1;
    logic         stall_mode = 1'b0;
    int           stall_left = 0;
    logic         nxt_v = 1'b0;
    logic [127:0] nxt_d = '0;
    logic [11:0]  log_addr [$];
    logic         log_we   [$];
    logic [127:0] log_wd   [$];
    int           ic_pulses = 0, dc_pulses = 0;
    int           ic_cyc = 0, dc_cyc = 0, acc_cyc = 0;
    logic [511:0] ic_data = '0, dc_data = '0;
    logic         prev_stall = 1'b0;
    logic [11:0]  prev_addr = '0;
    logic         prev_we = 1'b0;
    logic [127:0] prev_wd = '0;
    int           stab_bad = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] pat(input logic [11:0] a);
        return {20'hC0DE0, a, 32'h12345678, ~{20'h0, a}, 20'h0BADF, a};
    endfunction

    function automatic logic [511:0] exp_line(input logic [11:0] base);
        logic [511:0] r;
        for (int k = 0; k < 4; k++) r[k*128 +: 128] = pat(base + 12'(k));
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Memory: accepted read beats return one cycle later; optional random stalls.
    always @(posedge clk) begin
        #1;
        if (auto_rsp) begin
            mem_rsp_valid = nxt_v;
            mem_rsp_data  = nxt_d;
        end
        if (!stall_mode) begin
            mem_req_ready = 1'b1;
        end else if (stall_left == 0) begin
            mem_req_ready = 1'b1;
            stall_left = $urandom_range(0, 5);
        end else begin
            mem_req_ready = 1'b0;
            stall_left--;
        end
    end

    always @(negedge clk) begin
        nxt_v = 1'b0;
        if (mem_req_valid && mem_req_ready) begin
            log_addr.push_back(mem_req_addr);
            log_we.push_back(mem_req_we);
            log_wd.push_back(mem_req_wdata);
            nxt_v = !mem_req_we;
            nxt_d = pat(mem_req_addr);
        end
        if (prev_stall && !(mem_req_valid && mem_req_addr == prev_addr &&
                            mem_req_we == prev_we && mem_req_wdata == prev_wd)) stab_bad++;
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        prev_we    = mem_req_we;
        prev_wd    = mem_req_wdata;
        if (ic_rsp_valid) begin ic_pulses++; ic_cyc = cyc; ic_data = ic_rsp_data; end
        if (dc_rsp_valid) begin dc_pulses++; dc_cyc = cyc; dc_data = dc_rsp_data; end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clear_logs;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        ic_pulses = 0; dc_pulses = 0;
    endtask

    task automatic issue_ic(input logic [11:0] a);
        int n = 0;
        ic_req_valid = 1'b1; ic_req_addr = a;
        @(negedge clk);
        while (!ic_req_ready && n < 50) begin n++; @(negedge clk); end
        acc_cyc = cyc;
        chk("ic_accept", ic_req_ready, 1'b1);
        tick;
        ic_req_valid = 1'b0;
    endtask

    task automatic issue_dc(input logic [11:0] a, input logic we, input logic [511:0] wd);
        int n = 0;
        dc_req_valid = 1'b1; dc_req_addr = a; dc_req_we = we; dc_req_wdata = wd;
        @(negedge clk);
        while (!dc_req_ready && n < 50) begin n++; @(negedge clk); end
        acc_cyc = cyc;
        chk("dc_accept", dc_req_ready, 1'b1);
        tick;
        dc_req_valid = 1'b0; dc_req_wdata = '0;
    endtask

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin n++; @(negedge clk); end
        chk("idle", busy, 1'b0);
        tick;
    endtask

    task automatic chk_beats(input logic [11:0] base, input logic we, input logic [511:0] wl);
        chk("n_beats", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("beat_addr", log_addr[k], base + 12'(k));
                chk("beat_we", log_we[k], we);
                if (we) chk("beat_wdata", log_wd[k], wl[k*128 +: 128]);
            end
        end
    endtask

    task automatic chk_reset_outputs;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_mem_we", mem_req_we, 1'b0);
        chk("rst_mem_addr", mem_req_addr, 12'h000);
        chk("rst_ic_rsp", ic_rsp_valid, 1'b0);
        chk("rst_dc_rsp", dc_rsp_valid, 1'b0);
        chk("rst_ic_data", ic_rsp_data, 512'h0);
        chk("rst_ready", {ic_req_ready, dc_req_ready}, 2'b00);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] wl;
        int order [4];
        int g, n;

        // Reset state
        repeat (3) tick;
        @(negedge clk);
        chk_reset_outputs();
        tick;
        rst_n = 1'b1;

        // I$ read 0x041 -> beats 0x040..0x043, one ic pulse at c6
        clear_logs();
        issue_ic(12'h041);
        wait_idle();
        chk_beats(12'h040, 1'b0, '0);
        chk("ic_pulses", ic_pulses, 1);
        chk("ic_dc_quiet", dc_pulses, 0);
        chk("ic_line", ic_data, exp_line(12'h040));
        chk("ic_latency", ic_cyc - acc_cyc, 6);

        // D$ writeback 0x081 -> beats 0x080..0x083 carrying D0..D3, pulse at c5
        for (int k = 0; k < 4; k++) wl[k*128 +: 128] = {4{32'hDA7A0000 + 32'(k)}};
        clear_logs();
        issue_dc(12'h081, 1'b1, wl);
        wait_idle();
        chk_beats(12'h080, 1'b1, wl);
        chk("wr_pulses", dc_pulses, 1);
        chk("wr_ic_quiet", ic_pulses, 0);
        chk("wr_latency", dc_cyc - acc_cyc, 5);

        // Both held valid after reset: grant order
        rst_n = 1'b0; tick; tick; rst_n = 1'b1;
        clear_logs();
        ic_req_valid = 1'b1; ic_req_addr = 12'h400;
        dc_req_valid = 1'b1; dc_req_addr = 12'h500; dc_req_we = 1'b0;
        g = 0; n = 0;
        while (g < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (dc_req_ready) begin order[g] = 1; g++; end
            else if (ic_req_ready) begin order[g] = 0; g++; end
        end
        chk("grant_count", g, 4);
        tick;
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        wait_idle();
`ifdef MEM_ARB_DC_PRIO_EN
        for (int k = 0; k < 4; k++) chk("grant_order", order[k], 1);
        chk("tie_ic_pulses", ic_pulses, 0);
        chk("tie_dc_pulses", dc_pulses, 4);
`else
        for (int k = 0; k < 4; k++) chk("grant_order", order[k], (k % 2 == 0) ? 1 : 0);
        chk("tie_ic_pulses", ic_pulses, 2);
        chk("tie_dc_pulses", dc_pulses, 2);
        chk("tie_ic_line", ic_data, exp_line(12'h400));
`endif
        chk("tie_dc_line", dc_data, exp_line(12'h500));

        // Random memory stalls: read then writeback
        stall_mode = 1'b1;
        clear_logs();
        issue_ic(12'h105);
        wait_idle();
        chk_beats(12'h104, 1'b0, '0);
        chk("stall_ic_line", ic_data, exp_line(12'h104));
        for (int k = 0; k < 4; k++) wl[k*128 +: 128] = {4{32'h5EED0000 + 32'(k * 3)}};
        clear_logs();
        issue_dc(12'h0C3, 1'b1, wl);
        wait_idle();
        chk_beats(12'h0C0, 1'b1, wl);
        chk("stall_dc_pulses", dc_pulses, 1);
        stall_mode = 1'b0;
        tick; tick;
        chk("stall_stable", stab_bad, 0);

        // Reset after two read beats; two late responses arrive while in reset
        clear_logs();
        issue_ic(12'h200);
        n = 0;
        @(negedge clk);
        while (log_addr.size() < 2 && n < 50) begin n++; @(negedge clk); end
        chk("mid_beats", log_addr.size(), 2);
        auto_rsp = 1'b0;
        tick;
        rst_n = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'hDEADBEEF}};
        tick;
        mem_rsp_data = {4{32'hFEEDFACE}};
        @(negedge clk);
        chk_reset_outputs();
        tick;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        auto_rsp = 1'b1;
        tick; tick;
        chk("abort_ic_pulses", ic_pulses, 0);
        chk("abort_dc_pulses", dc_pulses, 0);
        clear_logs();
        issue_ic(12'h300);
        wait_idle();
        chk_beats(12'h300, 1'b0, '0);
        chk("post_abort_pulses", ic_pulses, 1);
        chk("post_abort_line", ic_data, exp_line(12'h300));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
